// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM/IO access sequencer.
package slc3_mem_pkg;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          WAIT_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } mem_state_t;
endpackage

// File: rtl/slc3_mem_ctrl.sv
// SRAM/IO access sequencer: turns one-cycle rd_req/wr_req pulses into SRAM strobe
// sequences, handles the memory-mapped IO address, and pulses done on completion.
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] switches,
  input  logic [15:0] sram_data_in,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [15:0] hex_out,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output mem_state_t  dbg_state
);

  // Handshake: the issuer pulses rd_req/wr_req for one cycle while busy=0, then waits
  // for the one-cycle done pulse; requests seen while busy (including DONE) are dropped.

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] count_q, count_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       hex_q, hex_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          addr_d  = addr;
          wdata_d = wdata;
          count_d = '0;
          if (addr == IO_ADDR) begin
            if (wr_req) hex_d = wdata;
            else        rdata_d = switches;
            state_d = ST_DONE;
          end else begin
            state_d = wr_req ? ST_WR_SETUP : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (count_q == WAIT_LAST) begin
          rdata_d = sram_data_in;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_WR_SETUP: state_d = ST_WRITE;
      ST_WRITE: begin
        if (count_q == WAIT_LAST) state_d = ST_WR_HOLD;
        else                      count_d = count_q + 1'b1;
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes depend on registered state only, so no input can glitch Mem_*.
  always_comb begin
    Mem_CE       = 1'b1;
    Mem_UB       = 1'b1;
    Mem_LB       = 1'b1;
    Mem_OE       = 1'b1;
    Mem_WE       = 1'b1;
    sram_data_oe = 1'b0;
    case (state_q)
      ST_READ: begin
        Mem_CE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_OE = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        Mem_CE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0; sram_data_oe = 1'b1;
      end
      ST_WRITE: begin
        Mem_CE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_WE = 1'b0; sram_data_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign done          = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign rdata         = rdata_q;
  assign hex_out       = hex_q;
  assign sram_addr     = {4'b0, addr_q};
  assign sram_data_out = wdata_q;
  assign dbg_state     = state_q;

endmodule
